// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: instruction fetch and data ports share a single
// strobe/ack bus, with optional round-robin and a bus-ack timeout abort.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int RR      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_sel,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stallreq_if,
   output logic        stallreq_mem,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       last_grant_dm;
   logic [7:0] cnt;
   logic       pick_dm;

   // On a tie the data port wins unless round-robin says fetch is due.
   assign pick_dm = dm_req && (!if_req || (RR == 0) || !last_grant_dm);

   assign stallreq_if  = if_req & ~if_ack;
   assign stallreq_mem = dm_req & ~dm_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         last_grant_dm <= 1'b0;
         cnt           <= '0;
         if_rdata      <= '0;
         if_ack        <= 1'b0;
         dm_rdata      <= '0;
         dm_ack        <= 1'b0;
         bus_stb       <= 1'b0;
         bus_we        <= 1'b0;
         bus_sel       <= '0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_err       <= 1'b0;
      end else begin
         if_ack  <= 1'b0;
         dm_ack  <= 1'b0;
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_dm) begin
                  state         <= BUSY_DM;
                  last_grant_dm <= 1'b1;
                  cnt           <= '0;
                  bus_stb       <= 1'b1;
                  bus_we        <= dm_we;
                  bus_sel       <= dm_sel;
                  bus_addr      <= dm_addr;
                  bus_wdata     <= dm_wdata;
               end else if (if_req) begin
                  state         <= BUSY_IF;
                  last_grant_dm <= 1'b0;
                  cnt           <= '0;
                  bus_stb       <= 1'b1;
                  bus_we        <= 1'b0;
                  bus_sel       <= 4'hF;
                  bus_addr      <= if_addr;
                  bus_wdata     <= '0;
               end
            end
            BUSY_IF, BUSY_DM: begin
               // A real ack beats a timeout landing on the same edge.
               if (bus_ack) begin
                  state   <= DONE;
                  bus_stb <= 1'b0;
                  if (state == BUSY_IF) begin
                     if_ack   <= 1'b1;
                     if_rdata <= bus_rdata;
                  end else begin
                     dm_ack <= 1'b1;
                     if (!bus_we) dm_rdata <= bus_rdata;
                  end
               end else if (cnt == CNT_LAST) begin
                  state   <= DONE;
                  bus_stb <= 1'b0;
                  bus_err <= 1'b1;
                  if (state == BUSY_IF) begin
                     if_ack   <= 1'b1;
                     if_rdata <= '0;
                  end else begin
                     dm_ack   <= 1'b1;
                     dm_rdata <= '0;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; bus slave modelled inline as acking
// one cycle after it sees the strobe unless a step says otherwise.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_sel;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        bus_stb;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        stallreq_if;
   logic        stallreq_mem;
   logic        bus_err;

   int compared;
   int mismatched;

   mem_bus_arbiter #(.TIMEOUT(16), .RR(1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      compared++;
      assert (obs === want) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_sel = '0; dm_addr = '0; dm_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_stb", 32'(bus_stb), 32'd0);
      chk("rst_if_ack", 32'(if_ack), 32'd0);
      chk("rst_dm_ack", 32'(dm_ack), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      if_req = 1'b1;
      #1;
      chk("rst_stallreq_if", 32'(stallreq_if), 32'd1);
      if_req = 1'b0;
      tick(); tick();
      chk("rst_held_stb", 32'(bus_stb), 32'd0);
      rst = 1'b1;

      // Single fetch with a one-cycle slave
      if_req = 1'b1; if_addr = 32'h0000_0004;
      tick();
      chk("f_stb", 32'(bus_stb), 32'd1);
      chk("f_addr", bus_addr, 32'h0000_0004);
      chk("f_we", 32'(bus_we), 32'd0);
      chk("f_sel", 32'(bus_sel), 32'hF);
      chk("f_wdata", bus_wdata, 32'd0);
      chk("f_stall", 32'(stallreq_if), 32'd1);
      tick();
      chk("f_no_early_ack", 32'(if_ack), 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h3C01_0001;
      tick();
      chk("f_ack", 32'(if_ack), 32'd1);
      chk("f_rdata", if_rdata, 32'h3C01_0001);
      chk("f_stb_drop", 32'(bus_stb), 32'd0);
      chk("f_stall_clear", 32'(stallreq_if), 32'd0);
      if_req = 1'b0; bus_ack = 1'b0;
      tick();
      chk("f_ack_pulse", 32'(if_ack), 32'd0);

      // Simultaneous load + fetch after reset: data first
      rst = 1'b0;
      tick();
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h0000_0200;
      dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0100;
      tick();
      chk("b_dm_first", bus_addr, 32'h0000_0100);
      chk("b_dm_we", 32'(bus_we), 32'd0);
      tick();
      bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
      tick();
      chk("b_dm_ack", 32'(dm_ack), 32'd1);
      chk("b_dm_rdata", dm_rdata, 32'hAAAA_5555);
      chk("b_if_wait", 32'(if_ack), 32'd0);
      chk("b_stall_if", 32'(stallreq_if), 32'd1);
      dm_req = 1'b0; bus_ack = 1'b0;
      tick();
      chk("b_done_stb", 32'(bus_stb), 32'd0);
      chk("b_dm_pulse", 32'(dm_ack), 32'd0);
      tick();
      chk("b_if_grant", bus_addr, 32'h0000_0200);
      chk("b_if_stb", 32'(bus_stb), 32'd1);
      tick();
      chk("b_stall_if2", 32'(stallreq_if), 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      tick();
      chk("b_if_ack", 32'(if_ack), 32'd1);
      chk("b_if_rdata", if_rdata, 32'h1234_5678);
      chk("b_dm_quiet", 32'(dm_ack), 32'd0);
      if_req = 1'b0; bus_ack = 1'b0;
      tick();

      // Store with three wait cycles; ack arrives while store keeps dm_rdata
      dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011;
      dm_addr = 32'h0000_0040; dm_wdata = 32'h0000_BEEF;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("s_stb", 32'(bus_stb), 32'd1);
         chk("s_fields", {bus_wdata[15:0], 7'd0, bus_we, bus_sel, bus_addr[7:0]},
             {16'hBEEF, 7'd0, 1'b1, 4'b0011, 8'h40});
         chk("s_no_ack", 32'(dm_ack), 32'd0);
         tick();
      end
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_DEAD;
      tick();
      chk("s_ack", 32'(dm_ack), 32'd1);
      chk("s_rdata_kept", dm_rdata, 32'hAAAA_5555);
      chk("s_no_err", 32'(bus_err), 32'd0);
      dm_req = 1'b0; bus_ack = 1'b0;
      tick();
      chk("s_ack_pulse", 32'(dm_ack), 32'd0);

      // Tie after a data grant: fetch wins, then load times out
      if_req = 1'b1; if_addr = 32'h0000_0300;
      dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0080;
      tick();
      chk("r_if_wins", bus_addr, 32'h0000_0300);
      chk("r_stall_mem", 32'(stallreq_mem), 32'd1);
      tick();
      bus_ack = 1'b1; bus_rdata = 32'h0000_0011;
      tick();
      chk("r_if_ack", 32'(if_ack), 32'd1);
      if_req = 1'b0; bus_ack = 1'b0;
      tick();
      tick();
      chk("t_grant", bus_addr, 32'h0000_0080);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("t_stb_held", 32'(bus_stb), 32'd1);
      end
      tick();
      chk("t_stb_drop", 32'(bus_stb), 32'd0);
      chk("t_ack", 32'(dm_ack), 32'd1);
      chk("t_rdata_zero", dm_rdata, 32'd0);
      chk("t_err", 32'(bus_err), 32'd1);
      dm_req = 1'b0;
      tick();
      chk("t_err_pulse", 32'(bus_err), 32'd0);

      // Ack on the very edge the timeout would fire
      dm_req = 1'b1; dm_addr = 32'h0000_0090;
      tick();
      chk("c_grant", bus_addr, 32'h0000_0090);
      for (int i = 0; i < 15; i++) tick();
      bus_ack = 1'b1; bus_rdata = 32'h0000_5A5A;
      tick();
      chk("c_ack", 32'(dm_ack), 32'd1);
      chk("c_no_err", 32'(bus_err), 32'd0);
      chk("c_rdata", dm_rdata, 32'h0000_5A5A);
      dm_req = 1'b0; bus_ack = 1'b0;
      tick();

      // Reset two cycles into a fetch, then fresh grant
      if_req = 1'b1; if_addr = 32'h0000_0500;
      tick();
      chk("x_stb", 32'(bus_stb), 32'd1);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("x_stb_async", 32'(bus_stb), 32'd0);
      chk("x_no_ack", 32'(if_ack), 32'd0);
      tick();
      chk("x_held_ack", 32'(if_ack), 32'd0);
      rst = 1'b1;
      tick();
      chk("x_regrant_stb", 32'(bus_stb), 32'd1);
      chk("x_regrant_addr", bus_addr, 32'h0000_0500);
      tick();
      bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
      tick();
      chk("x_ack", 32'(if_ack), 32'd1);
      chk("x_rdata", if_rdata, 32'hCAFE_0001);
      if_req = 1'b0; bus_ack = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
